fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Program-counter and fetch stage that sits directly upstream of instruction_memory.
- Drives the memory address, captures the combinationally returned instruction, and buffers {pc, instr} pairs in a small queue for the decode stage.
- Decode handshake is valid/ready.
- Supports a single-cycle redirect (branch/jump/exception) that flushes buffered work.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width (word addressed).
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- QUEUE_DEPTH, 2, fetch queue entries; must be a power of two and at least 2.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  fetch permitted when high.
- imem_addr  out  ADDR_W  address to instruction_memory; equals the PC register.
- imem_instr  in  INSTR_W  instruction returned combinationally for imem_addr.
- redirect_valid  in  1  load new PC and flush the queue.
- redirect_pc  in  ADDR_W  redirect target.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  address of the head instruction.
- halted  out  1  fetch halted (see Optional Feature).

Behaviour:
- Reset: pc=RESET_PC; queue empty; state=IDLE; out_valid=0; out_instr=0; out_pc=0; halted=0.
- imem_addr is driven straight from the pc register, with no combinational path from inputs.
- States:
  - IDLE: enable=0.
  - FETCH: enable=1.
  - HALT: only with the optional feature.
  - IDLE<->FETCH follows enable each cycle.
  - redirect_valid forces FETCH if enable=1, otherwise IDLE.
- Push condition: state FETCH, no redirect, and (count<QUEUE_DEPTH or pop this cycle).
  - On push: enqueue {pc, imem_instr}; pc <= pc+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
- Pop: out_valid && out_ready; removes the head.
  - out_instr/out_pc hold the head entry and are stable while out_valid=1 && out_ready=0.
- Full with simultaneous pop: push and pop both happen; count unchanged. No throughput bubble.
- Empty: out_valid=0; no pop occurs regardless of out_ready.
- Latency: with the queue empty, the instruction at pc=A appears with out_valid=1 the cycle after imem_addr==A. Steady-state throughput is 1 instruction/cycle.
- Redirect has highest priority (after rst):
  - same edge: queue cleared, pc <= redirect_pc, no push.
  - any pop that cycle is discarded.
  - next cycle: out_valid=0; fetch of redirect_pc begins.
- enable=0: pc holds; the queue still drains to decode.
- rst asserted mid-operation overrides redirect and enable; all state returns to reset values on that edge.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - A pushed instruction equal to HALT_OPCODE (16'hFFFF) is still enqueued; state then goes to HALT.
  - In HALT: pc frozen at halt address+1; no pushes; halted=1; the queue still drains.
  - HALT exits only on redirect_valid (to FETCH/IDLE per enable, halted=0 next cycle) or rst.
- Not defined: 16'hFFFF is fetched as an ordinary instruction; HALT is unreachable; halted is tied 0.

Decomposition:
- Package fetch_pkg holds:
  - ADDR_W/INSTR_W defaults.
  - HALT_OPCODE.
  - typedef fetch_entry_t {pc, instr}.
  - enum fetch_state_t {IDLE, FETCH, HALT}.
- Sub-module fetch_queue: parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count, full, empty.
  - Flush has priority over push/pop.
  - Head is exposed combinationally from storage.
- fetch_unit holds the PC, the state machine, and the push/redirect logic.

Test Plan:
- Linear fetch: rst, enable=1, out_ready=1, memory[n]=n+0x100. Expect imem_addr 0,1,2,… each cycle; out_pc/out_instr 0/0x100 on cycle 2, then 1/0x101, … with no bubbles.
- Backpressure: out_ready=0 for 5 cycles. Queue fills after 2 pushes; pc stops at 2; out_instr stays 0x100. Release out_ready: pcs 0,1,2,3 are delivered in order with none lost or duplicated.
- Redirect with a full queue plus simultaneous pop: redirect_pc=0x0040. Next cycle out_valid=0 and imem_addr=0x0040. The following cycle out_pc=0x0040; none of the flushed pcs reappear.
- Wrap-around: redirect to 0xFFFE. Expect out_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-operation: rst with redirect_valid=1 and a full queue. Next cycle imem_addr=RESET_PC, out_valid=0, out_instr=0.
- FETCH_HALT_DETECT_EN: memory[3]=0xFFFF. Pcs 0–3 are delivered; halted=1; imem_addr stays 4. Redirect to 0x0010 clears halted and fetch resumes. Without the macro, pc 4 follows pc 3 and halted=0 throughout.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch stage.
package fetch_pkg;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 16;
  localparam logic [DEF_INSTR_W-1:0] HALT_OPCODE = 16'hFFFF;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush wins over push/pop, head read straight from storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  entry_t                   din,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full queue can still accept.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wptr] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// PC register, fetch FSM and {pc, instr} queue feeding decode.
// Optional halt-opcode detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W      = DEF_ADDR_W,
  parameter int                 INSTR_W     = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int                 QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_t                 state;
  logic [ADDR_W-1:0]            pc;
  entry_t                       q_din, q_head;
  logic [$clog2(QUEUE_DEPTH):0] q_count;
  logic                         q_full, q_empty;
  logic                         push, pop;

  assign imem_addr = pc;
  assign pop       = out_ready && !q_empty;
  assign push      = (state == FETCH) && !redirect_valid && (!q_full || pop);
  assign q_din     = '{pc: pc, instr: imem_instr};

  assign out_valid = (q_count != '0);
  // Zero the head when empty so outputs read 0 after reset or flush.
  assign out_pc    = q_empty ? '0 : q_head.pc;
  assign out_instr = q_empty ? '0 : q_head.instr;

  fetch_queue #(.DEPTH(QUEUE_DEPTH), .entry_t(entry_t)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else if (redirect_valid) begin
      state <= enable ? FETCH : IDLE;
      pc    <= redirect_pc;
    end else begin
      if (push) pc <= pc + ADDR_W'(1);
`ifdef FETCH_HALT_DETECT_EN
      if (state == HALT)
        state <= HALT;
      else if (push && imem_instr == INSTR_W'(HALT_OPCODE))
        state <= HALT;
      else
        state <= enable ? FETCH : IDLE;
`else
      state <= enable ? FETCH : IDLE;
`endif
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif
endmodule
